// File: rtl/hqm_list_sel_rf_access_pkg.sv
// Shared constants and request/record types for the list-select 32x96 RF access pipe.
package hqm_list_sel_rf_access_pkg;

  localparam int unsigned DEPTH      = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned DW         = 96;
  localparam int unsigned RSPQ_DEPTH = 2;
  localparam int unsigned RSPQ_CW    = $clog2(RSPQ_DEPTH + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } rf_req_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } rf_lastwr_t;

endpackage

// File: rtl/hqm_list_sel_rf_rspq.sv
// Small response FIFO with synchronous flush; head entry is always presented on o_data.
module hqm_list_sel_rf_rspq
  import hqm_list_sel_rf_access_pkg::*;
#(
  parameter int unsigned DATA_W  = DW,
  parameter int unsigned ENTRIES = RSPQ_DEPTH,
  localparam int unsigned PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int unsigned CW = $clog2(ENTRIES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [ENTRIES];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(ENTRIES));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;

  // Storage, pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= f_inc(r_wptr);
      end
      if (w_pop) r_rptr <= f_inc(r_rptr);
      if (i_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/hqm_list_sel_rf_32x96_access_pipe.sv
// Request-side access controller for the list-select 32x96 power-gated RF:
// drives RF ports, queues read data under credit, forwards RAW data, fences on power-down.
module hqm_list_sel_rf_32x96_access_pipe
  import hqm_list_sel_rf_access_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req_v,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_v,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_pwr_enable_b,
  output logic          pwr_flush
);

  logic               r_pwr_ok;
  logic               r_inflight;
  logic               r_fwd_sel;
  logic [DW-1:0]      r_fwd_data;
  rf_lastwr_t         r_lastwr;

  rf_req_t            w_req;
  logic               w_acc_wr;
  logic               w_acc_rd;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [RSPQ_CW-1:0] w_count;
  logic [RSPQ_CW:0]   w_used;
  logic [DW-1:0]      w_push_data;

  assign w_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

  // A pop in the current cycle frees its slot immediately, which is what lets
  // back-to-back reads run at one per cycle while the consumer keeps up.
  assign w_used    = {1'b0, w_count} + {{RSPQ_CW{1'b0}}, r_inflight}
                   - {{RSPQ_CW{1'b0}}, w_pop};
  assign req_ready = r_pwr_ok & (w_used < (RSPQ_CW + 1)'(RSPQ_DEPTH));

  assign w_acc_wr  = req_v & req_ready & w_req.we;
  assign w_acc_rd  = req_v & req_ready & ~w_req.we;

  assign mem_we    = w_acc_wr;
  assign mem_waddr = w_acc_wr ? w_req.addr  : '0;
  assign mem_wdata = w_acc_wr ? w_req.wdata : '0;
  assign mem_re    = w_acc_rd;
  assign mem_raddr = w_acc_rd ? w_req.addr  : '0;

  // Read data lands one cycle after mem_re; a powered-down cycle drops it.
  assign w_push      = r_inflight & r_pwr_ok;
  assign w_push_data = r_fwd_sel ? r_fwd_data : mem_rdata;

  // Head is withheld during the flush cycle since it is being discarded.
  assign rsp_v     = ~w_empty & r_pwr_ok;
  assign w_pop     = rsp_v & rsp_ready;
  assign pwr_flush = ~rst & ~r_pwr_ok & (r_inflight | ~w_empty);

  // Power sampling, in-flight/forward tracking and the one-cycle last-write record.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwr_ok   <= 1'b0;
      r_inflight <= 1'b0;
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
      r_lastwr   <= '0;
    end else begin
      r_pwr_ok   <= ~mem_pwr_enable_b;
      r_inflight <= w_acc_rd;
      if (w_acc_rd) begin
        r_fwd_sel  <= r_lastwr.v & (r_lastwr.addr == w_req.addr);
        r_fwd_data <= r_lastwr.wdata;
      end
      r_lastwr.v <= w_acc_wr;
      if (w_acc_wr) begin
        r_lastwr.addr  <= w_req.addr;
        r_lastwr.wdata <= w_req.wdata;
      end
    end
  end

  hqm_list_sel_rf_rspq #(
    .DATA_W  (DW),
    .ENTRIES (RSPQ_DEPTH)
  ) u_rspq (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (~r_pwr_ok),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_data  (rsp_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_hqm_list_sel_rf_32x96_access_pipe.sv
// Scoreboard bench for the list-select RF access pipe with a delayed-write RF model.
module tb_hqm_list_sel_rf_32x96_access_pipe;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 96;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_v;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_v;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_pwr_enable_b;
  logic          pwr_flush;

  always #5 clk = ~clk;

  hqm_list_sel_rf_32x96_access_pipe dut (
    .clk              (clk),
    .rst              (rst),
    .req_v            (req_v),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_v            (rsp_v),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .mem_we           (mem_we),
    .mem_waddr        (mem_waddr),
    .mem_wdata        (mem_wdata),
    .mem_re           (mem_re),
    .mem_raddr        (mem_raddr),
    .mem_rdata        (mem_rdata),
    .mem_pwr_enable_b (mem_pwr_enable_b),
    .pwr_flush        (pwr_flush)
  );

  // RF model: writes land one edge late, so a read right after a write sees stale data.
  logic [DW-1:0] rf [32] = '{default: '0};
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_a = '0;
  logic [DW-1:0] pend_d = '0;

  always @(posedge clk) begin
    if (mem_pwr_enable_b) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      pend_v <= 1'b0;
    end else begin
      if (pend_v) rf[pend_a] <= pend_d;
      pend_v <= mem_we;
      pend_a <= mem_waddr;
      pend_d <= mem_wdata;
    end
    if (mem_re) mem_rdata <= rf[mem_raddr];
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rr_mode = 1;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_q [$];
  int            rsp_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Consumer ready: 0 = stalled, 1 = always ready, otherwise random.
  initial forever begin
    @(negedge clk);
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: every delivered response is checked against the head of the expected queue.
  initial begin : mon
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && rsp_v && rsp_ready) begin
        rsp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: actual=%h required=no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e);
        end
      end
    end
  end

  // Present one request; returns at the sample point just before the accepting edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int waited);
    waited = 0;
    @(negedge clk);
    req_v = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    #4;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      #4;
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept: ready=0 required=1 after %0d cycles", waited);
    end else if (we) begin
      ref_mem[a] = d;
    end else begin
      exp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_v = 1'b0;
    #4;
  endtask

  function automatic logic [DW-1:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w;
    int mx;
    int pulses;
    int gaps;
    int n;
    logic [DW-1:0] a5;
    logic [AW-1:0] ad;

    rst = 1'b1; req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_pwr_enable_b = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    rr_mode = 1;

    // Reset state
    repeat (3) @(negedge clk);
    #4;
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_rsp_v", rsp_v, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_waddr", DW'(mem_waddr), '0);
    chk("rst_mem_raddr", DW'(mem_raddr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk1("rst_pwr_flush", pwr_flush, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk1("rel_ready_latency", req_ready, 1'b0);
    idle();
    chk1("rel_ready_up", req_ready, 1'b1);

    // Write then read the same address later: 2-cycle read latency
    a5 = {12{8'hA5}};
    send(1'b1, 5'd5, a5, w);
    chk1("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_waddr", DW'(mem_waddr), DW'(5));
    chk("wr_mem_wdata", mem_wdata, a5);
    repeat (3) idle();
    send(1'b0, 5'd5, '0, w);
    chk1("rd_mem_re", mem_re, 1'b1);
    chk("rd_mem_raddr", DW'(mem_raddr), DW'(5));
    idle();
    chk1("rd_mem_re_1cyc", mem_re, 1'b0);
    chk1("rd_rsp_not_early", rsp_v, 1'b0);
    idle();
    chk1("rd_rsp_at_2", rsp_v, 1'b1);
    repeat (2) idle();

    // Read right after write to same address must be forwarded
    send(1'b1, 5'd7, 96'h1, w);
    send(1'b0, 5'd7, '0, w);
    repeat (4) idle();

    // Credit limit with a stalled consumer
    for (int i = 1; i <= 3; i++) send(1'b1, AW'(i), rnd96(), w);
    repeat (3) idle();
    rr_mode = 0;
    idle();
    send(1'b0, 5'd1, '0, w);
    send(1'b0, 5'd2, '0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_v = 1'b1; req_we = 1'b0; req_addr = 5'd3;
      #4;
      chk1("credit_block", req_ready, 1'b0);
    end
    rr_mode = 1;
    send(1'b0, 5'd3, '0, w);
    repeat (5) idle();
    chk("credit_drained", DW'(exp_q.size()), '0);

    // Power-down with a read in flight
    @(negedge clk);
    mem_pwr_enable_b = 1'b1;
    req_v = 1'b1; req_we = 1'b0; req_addr = 5'd4;
    #4;
    chk1("pd_read_accept", req_ready, 1'b1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k == 0) chk1("pd_flush_pulse", pwr_flush, 1'b1);
      if (pwr_flush) pulses++;
      chk1("pd_ready_low", req_ready, 1'b0);
    end
    chk("pd_flush_count", DW'(pulses), DW'(1));
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    @(negedge clk);
    mem_pwr_enable_b = 1'b0;
    #4;
    chk1("pu_ready_latency", req_ready, 1'b0);
    idle();
    chk1("pu_ready_up", req_ready, 1'b1);

    // Power-down with nothing outstanding raises no flush
    @(negedge clk);
    mem_pwr_enable_b = 1'b1;
    #4;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (pwr_flush) pulses++;
    end
    chk("pd_idle_no_flush", DW'(pulses), '0);
    @(negedge clk);
    mem_pwr_enable_b = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (2) idle();

    // Reset with two queued responses
    send(1'b1, 5'd10, rnd96(), w);
    send(1'b1, 5'd11, rnd96(), w);
    repeat (3) idle();
    rr_mode = 0;
    idle();
    send(1'b0, 5'd10, '0, w);
    send(1'b0, 5'd11, '0, w);
    repeat (3) idle();
    chk1("rst_mid_queued", rsp_v, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #4;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #4;
    chk1("rst_mid_rsp_v", rsp_v, 1'b0);
    chk1("rst_mid_ready", req_ready, 1'b0);
    chk1("rst_mid_no_flush", pwr_flush, 1'b0);
    idle();
    chk1("rst_mid_ready_up", req_ready, 1'b1);
    rr_mode = 1;
    idle();

    // Full sweep of reads at one per cycle
    for (int i = 0; i < 32; i++) send(1'b1, AW'(i), rnd96(), w);
    repeat (4) idle();
    rsp_cyc_q.delete();
    mx = 0;
    for (int i = 0; i < 32; i++) begin
      send(1'b0, AW'(i), '0, w);
      if (w > mx) mx = w;
    end
    repeat (5) idle();
    chk("sweep_stall", DW'(mx), '0);
    chk("sweep_rsp_count", DW'(rsp_cyc_q.size()), DW'(32));
    gaps = 0;
    for (int j = 1; j < rsp_cyc_q.size(); j++)
      if (rsp_cyc_q[j] != rsp_cyc_q[j-1] + 1) gaps++;
    chk("sweep_bubbles", DW'(gaps), '0);

    // Random mixed traffic with a jittery consumer
    rr_mode = 2;
    for (int t = 0; t < 400; t++) begin
      ad = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
      send(($urandom_range(0, 1) != 0), ad, rnd96(), w);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rr_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle();
      n++;
    end
    chk("drain_empty", DW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
